// File: rtl/maf_pkg.sv
// rtl/maf_pkg.sv - mode encodings, default geometry and lane helper for the MAF CSA stage
package maf_pkg;
   localparam logic [2:0] MAF_MODE_FULL = 3'b000;
   localparam logic [2:0] MAF_MODE_PACK = 3'b001;
   localparam logic [2:0] MAF_MODE_ISO  = 3'b010;

   localparam int MAF_WIDTH_DEF = 48;
   localparam int MAF_LANES_DEF = 2;

   function automatic int maf_lane_base(input int lane, input int lane_w);
      return lane * lane_w;
   endfunction
endpackage

// File: rtl/maf_csa_corr_row.sv
// rtl/maf_csa_corr_row.sv - correction operand build, 3:2 compression row and lane carry masking
// MAF_CSA_SELFCHECK_EN adds the ref_val reference-sum output.
module maf_csa_corr_row
   import maf_pkg::*;
#(
   parameter int WIDTH = MAF_WIDTH_DEF,
   parameter int LANES = MAF_LANES_DEF
) (
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [LANES-1:0] inv,
   input  logic [2:0]       mode,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH:0]   carry
`ifdef MAF_CSA_SELFCHECK_EN
   ,
   output logic [WIDTH:0]   ref_val
`endif
);
   localparam int LANE_W = WIDTH / LANES;

   if (WIDTH % LANES != 0) begin : g_bad_geometry
      $error("maf_csa_corr_row: WIDTH must be a multiple of LANES");
   end

   logic [WIDTH-1:0] corr_pack;
   logic [WIDTH-1:0] t_iso;
   logic [WIDTH:0]   lane_kill;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] maj;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam int B = maf_lane_base(k, LANE_W);
      assign corr_pack[B +: LANE_W] = LANE_W'(inv[k]);
      assign t_iso[B +: LANE_W]     = in2[B +: LANE_W] + LANE_W'(inv[k]);
      // Lane 0 has no lower neighbour, so only the upper lane bases are cleared.
      assign lane_kill[B +: LANE_W] = LANE_W'(k != 0);
   end
   assign lane_kill[WIDTH] = 1'b0;

   always_comb begin
      case (mode)
         MAF_MODE_FULL: t = in2 + WIDTH'(inv[0]);
         MAF_MODE_PACK: t = in2 + corr_pack;
         MAF_MODE_ISO:  t = t_iso;
         default:       t = in2;
      endcase
      sum   = in1 ^ t ^ in3;
      maj   = (in1 & t) | (in1 & in3) | (t & in3);
      carry = {maj, 1'b0};
      if (mode == MAF_MODE_ISO) carry = carry & ~lane_kill;
   end

`ifdef MAF_CSA_SELFCHECK_EN
   logic [WIDTH:0] ref_iso;

   for (genvar k = 0; k < LANES; k++) begin : g_ref
      localparam int B = maf_lane_base(k, LANE_W);
      assign ref_iso[B +: LANE_W] = in1[B +: LANE_W] + t_iso[B +: LANE_W] + in3[B +: LANE_W];
   end
   assign ref_iso[WIDTH] = 1'b0;

   assign ref_val = (mode == MAF_MODE_ISO) ? ref_iso
                                           : ({1'b0, in1} + {1'b0, t} + {1'b0, in3});
`endif
endmodule

// File: rtl/maf_csa_lane_stage.sv
// rtl/maf_csa_lane_stage.sv - registered 3:2 CSA stage with lane corrections and a 2-entry output FIFO
// MAF_CSA_SELFCHECK_EN adds chk_err and a per-entry reference sum.
module maf_csa_lane_stage
   import maf_pkg::*;
#(
   parameter int WIDTH = MAF_WIDTH_DEF,
   parameter int LANES = MAF_LANES_DEF,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [LANES-1:0] inv,
   input  logic [2:0]       mode,
   input  logic [TAG_W-1:0] tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH:0]   carry,
   output logic [TAG_W-1:0] out_tag,
   output logic [2:0]       out_mode
`ifdef MAF_CSA_SELFCHECK_EN
   ,
   output logic             chk_err
`endif
);
   logic [WIDTH-1:0] row_sum;
   logic [WIDTH:0]   row_carry;
   logic [WIDTH-1:0] sum_mem_q [2], sum_mem_d [2];
   logic [WIDTH:0]   carry_mem_q [2], carry_mem_d [2];
   logic [TAG_W-1:0] tag_mem_q [2], tag_mem_d [2];
   logic [2:0]       mode_mem_q [2], mode_mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             in_ready_q, in_ready_d;
   logic             accept, deliver;
`ifdef MAF_CSA_SELFCHECK_EN
   logic [WIDTH:0]   row_ref;
`endif

   maf_csa_corr_row #(.WIDTH(WIDTH), .LANES(LANES)) u_row (
      .in1   (in1),
      .in2   (in2),
      .in3   (in3),
      .inv   (inv),
      .mode  (mode),
      .sum   (row_sum),
      .carry (row_carry)
`ifdef MAF_CSA_SELFCHECK_EN
      ,
      .ref_val (row_ref)
`endif
   );

   assign accept    = in_valid && in_ready_q;
   assign out_valid = (count_q != 2'd0);
   assign deliver   = out_valid && out_ready;
   assign in_ready  = in_ready_q;
   assign sum       = sum_mem_q[rd_ptr_q];
   assign carry     = carry_mem_q[rd_ptr_q];
   assign out_tag   = tag_mem_q[rd_ptr_q];
   assign out_mode  = mode_mem_q[rd_ptr_q];

   always_comb begin
      sum_mem_d   = sum_mem_q;
      carry_mem_d = carry_mem_q;
      tag_mem_d   = tag_mem_q;
      mode_mem_d  = mode_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (accept) begin
         sum_mem_d[wr_ptr_q]   = row_sum;
         carry_mem_d[wr_ptr_q] = row_carry;
         tag_mem_d[wr_ptr_q]   = tag;
         mode_mem_d[wr_ptr_q]  = mode;
         wr_ptr_d              = ~wr_ptr_q;
      end
      if (deliver) rd_ptr_d = ~rd_ptr_q;
      case ({accept, deliver})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      // Ready is registered, so it must look at the occupancy after this edge.
      in_ready_d = (count_d < 2'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            sum_mem_q[i]   <= '0;
            carry_mem_q[i] <= '0;
            tag_mem_q[i]   <= '0;
            mode_mem_q[i]  <= '0;
         end
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         in_ready_q <= 1'b0;
      end else begin
         sum_mem_q   <= sum_mem_d;
         carry_mem_q <= carry_mem_d;
         tag_mem_q   <= tag_mem_d;
         mode_mem_q  <= mode_mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
      end
   end

`ifdef MAF_CSA_SELFCHECK_EN
   localparam int LANE_W = WIDTH / LANES;
   logic [WIDTH:0]   ref_mem_q [2], ref_mem_d [2];
   logic [WIDTH:0]   out_ref;
   logic [LANES-1:0] lane_bad;
   logic             full_bad;

   assign out_ref  = ref_mem_q[rd_ptr_q];
   assign full_bad = (({1'b0, sum} + carry) != out_ref);

   for (genvar k = 0; k < LANES; k++) begin : g_chk
      localparam int B = maf_lane_base(k, LANE_W);
      assign lane_bad[k] = (LANE_W'(sum[B +: LANE_W] + carry[B +: LANE_W]) != out_ref[B +: LANE_W]);
   end

   assign chk_err = out_valid && ((out_mode == MAF_MODE_ISO) ? (|lane_bad) : full_bad);

   always_comb begin
      ref_mem_d = ref_mem_q;
      if (accept) ref_mem_d[wr_ptr_q] = row_ref;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) ref_mem_q[i] <= '0;
      end else begin
         ref_mem_q <= ref_mem_d;
      end
   end
`endif
endmodule

// File: tb/tb_maf_csa_lane_stage.sv
// tb/tb_maf_csa_lane_stage.sv - directed and randomized scoreboard bench for maf_csa_lane_stage
module tb_maf_csa_lane_stage;
   localparam int W  = 48;
   localparam int L  = 2;
   localparam int TW = 4;

   typedef struct {
      logic [W-1:0]  sum;
      logic [W:0]    carry;
      logic [TW-1:0] tag;
      logic [2:0]    mode;
   } exp_t;

   typedef struct {
      logic [W-1:0] a, b, c;
      logic [1:0]   iv;
      logic [2:0]   md;
      logic [W-1:0] es;
      logic [W:0]   ec;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in1 = '0, in2 = '0, in3 = '0;
   logic [L-1:0]  inv = '0;
   logic [2:0]    mode = '0;
   logic [TW-1:0] tag = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  sum;
   logic [W:0]    carry;
   logic [TW-1:0] out_tag;
   logic [2:0]    out_mode;

   int            tests = 0;
   int            fails = 0;
   exp_t          q[$];
   logic [TW-1:0] got_tags[$];
   logic          armed = 1'b0;
   logic          rand_done = 1'b0;

   maf_csa_lane_stage #(.WIDTH(W), .LANES(L), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .inv       (inv),
      .mode      (mode),
      .tag       (tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .out_tag   (out_tag),
      .out_mode  (out_mode)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference: t from lane arithmetic, carry = (a+t+c) - (a^t^c).
   function automatic exp_t model(input logic [W-1:0] a, b, c, input logic [1:0] iv,
                                  input logic [2:0] md, input logic [TW-1:0] tg);
      longint unsigned m48 = 64'h1 << 48;
      longint unsigned m24 = 64'h1 << 24;
      longint unsigned ua = 64'(a), ub = 64'(b), uc = 64'(c);
      longint unsigned t, s, tot;
      exp_t e;
      case (md)
         3'd0:    t = (ub + 64'(iv[0])) % m48;
         3'd1:    t = (ub + 64'(iv[0]) + (iv[1] ? m24 : 64'd0)) % m48;
         3'd2:    t = (((ub / m24) + 64'(iv[1])) % m24) * m24 + (((ub % m24) + 64'(iv[0])) % m24);
         default: t = ub;
      endcase
      s   = ua ^ t ^ uc;
      tot = ua + t + uc;
      e.sum   = 48'(s);
      e.carry = 49'(tot - s);
      if (md == 3'd2) e.carry[24] = 1'b0;
      e.tag  = tg;
      e.mode = md;
      return e;
   endfunction

   function automatic logic [W-1:0] rnd48();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 48'h0000_00FF_FFFF;
         3:       return 48'h8000_0080_0000;
         default: return {16'($urandom()), 32'($urandom())};
      endcase
   endfunction

   task automatic send(input logic [W-1:0] a, b, c, input logic [1:0] iv,
                       input logic [2:0] md, input logic [TW-1:0] tg);
      int n = 0;
      in1 = a; in2 = b; in3 = c; inv = iv; mode = md; tag = tg;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      chk("send_accept", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial forever begin
      @(posedge clk);
      if (rst_n) armed = 1'b1;
   end

   initial forever begin
      @(negedge rst_n);
      q.delete();
      armed = 1'b0;
   end

   // Per-cycle compare, then advance the model by what the coming edge will do.
   initial forever begin
      @(negedge clk);
      if (rst_n && armed) begin
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
         if (out_valid && q.size() != 0) begin
            chk("sum", 64'(sum), 64'(q[0].sum));
            chk("carry", 64'(carry), 64'(q[0].carry));
            chk("out_tag", 64'(out_tag), 64'(q[0].tag));
            chk("out_mode", 64'(out_mode), 64'(q[0].mode));
         end
         if (out_valid && out_ready) begin
            got_tags.push_back(out_tag);
            if (q.size() != 0) void'(q.pop_front());
         end
         if (in_valid && in_ready) q.push_back(model(in1, in2, in3, inv, mode, tag));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

   initial begin
      vec_t dir[5];
      exp_t e;
      int   n;

      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_carry", 64'(carry), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_out_mode", 64'(out_mode), 64'd0);

      e = model(48'h8000_0080_0000, 48'h0, 48'h8000_0080_0000, 2'b00, 3'b010, 4'h0);
      chk("model_pin_iso_carry", 64'(e.carry), 64'h1_0000_0000_0000);
      e = model(48'h0, 48'h0, 48'h0, 2'b11, 3'b001, 4'h0);
      chk("model_pin_pack_sum", 64'(e.sum), 64'h0000_0100_0001);
      e = model(48'h1, 48'h2, 48'h3, 2'b00, 3'b000, 4'h0);
      chk("model_pin_full_carry", 64'(e.carry), 64'h6);

      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_release_in_ready", 64'(in_ready), 64'd1);

      dir[0] = '{a: 48'h0, b: 48'hFFFF_FFFF_FFFF, c: 48'h0, iv: 2'b01, md: 3'b000, es: 48'h0, ec: 49'h0};
      dir[1] = '{a: 48'h0, b: 48'h0, c: 48'h0, iv: 2'b11, md: 3'b001, es: 48'h0000_0100_0001, ec: 49'h0};
      dir[2] = '{a: 48'h0, b: 48'hFFFF_FFFF_FFFF, c: 48'h0, iv: 2'b11, md: 3'b010, es: 48'h0, ec: 49'h0};
      dir[3] = '{a: 48'h8000_0080_0000, b: 48'h0, c: 48'h8000_0080_0000, iv: 2'b00, md: 3'b010,
                 es: 48'h0, ec: 49'h1_0000_0000_0000};
      dir[4] = '{a: 48'h1, b: 48'h2, c: 48'h4, iv: 2'b11, md: 3'b101, es: 48'h7, ec: 49'h0};
      for (int i = 0; i < 5; i++) begin
         send(dir[i].a, dir[i].b, dir[i].c, dir[i].iv, dir[i].md, 4'(i + 8));
         @(negedge clk);
         chk("dir_out_valid", 64'(out_valid), 64'd1);
         chk("dir_sum", 64'(sum), 64'(dir[i].es));
         chk("dir_carry", 64'(carry), 64'(dir[i].ec));
         chk("dir_out_mode", 64'(out_mode), 64'(dir[i].md));
         chk("dir_out_tag", 64'(out_tag), 64'(i + 8));
         @(posedge clk);
         #1;
      end

      out_ready = 1'b0;
      got_tags.delete();
      send(rnd48(), rnd48(), rnd48(), 2'b01, 3'b000, 4'd1);
      send(rnd48(), rnd48(), rnd48(), 2'b10, 3'b001, 4'd2);
      fork
         send(rnd48(), rnd48(), rnd48(), 2'b11, 3'b010, 4'd3);
         begin
            @(negedge clk);
            chk("bp_in_ready_full", 64'(in_ready), 64'd0);
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk("bp_drained", 64'(q.size()), 64'd0);
      chk("bp_tag_count", 64'(got_tags.size()), 64'd3);
      for (int i = 0; i < 3; i++) chk("bp_tag_order", 64'(got_tags[i]), 64'(i + 1));

      @(posedge clk);
      #1 out_ready = 1'b0;
      send(rnd48(), rnd48(), rnd48(), 2'b00, 3'b001, 4'd5);
      send(rnd48(), rnd48(), rnd48(), 2'b11, 3'b000, 4'd6);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_sum", 64'(sum), 64'd0);
      chk("midrst_out_tag", 64'(out_tag), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      got_tags.delete();
      @(posedge clk);
      repeat (4) begin
         @(negedge clk);
         chk("postrst_out_valid", 64'(out_valid), 64'd0);
         chk("postrst_in_ready", 64'(in_ready), 64'd1);
      end
      chk("postrst_no_stale", 64'(got_tags.size()), 64'd0);
      @(posedge clk);
      #1;

      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(rnd48(), rnd48(), rnd48(), 2'($urandom()), 3'($urandom()), 4'($urandom()));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join

      out_ready = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk("final_drained", 64'(q.size()), 64'd0);
      chk("final_out_valid", 64'(out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
